// File: rtl/prt_rcfg_resp.sv
// Avalon-MM reconfiguration responder: single-word read/write target over an
// internal register bank with programmable access latency and parallel export.
module prt_rcfg_resp #(
    parameter int unsigned         P_ADR     = 10,
    parameter int unsigned         P_DAT     = 32,
    parameter int unsigned         P_REGS    = 16,
    parameter int unsigned         P_LAT     = 2,
    parameter logic [P_DAT-1:0]    P_OOR_DAT = P_DAT'(32'hDEAD_BEEF)
) (
    input  logic                    CLK_IN,
    input  logic                    RSTN_IN,
    input  logic [P_ADR-1:0]        RCFG_ADR_IN,
    input  logic                    RCFG_WR_IN,
    input  logic                    RCFG_RD_IN,
    input  logic [P_DAT-1:0]        RCFG_DAT_IN,
    output logic [P_DAT-1:0]        RCFG_DAT_OUT,
    output logic                    RCFG_WAIT_OUT,
    input  logic                    HOLD_IN,
    output logic [P_REGS*P_DAT-1:0] REG_OUT,
    output logic                    ERR_OUT,
    input  logic                    ERR_CLR_IN
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LAT_INIT = (P_LAT == 0) ? '0 : CW'(P_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAT,
        S_DONE
    } state_t;

    state_t           state_q, state_nxt;
    logic [CW-1:0]    cnt_q, cnt_nxt;
    logic [P_ADR-1:0] adr_q;
    logic [P_DAT-1:0] dat_q;
    logic             wr_q;
    logic             wait_q;
    logic [P_DAT-1:0] rdat_q;
    logic             err_q;
    logic [P_DAT-1:0] regs_q [P_REGS];

    logic             capture_c;
    logic             commit_c;
    logic             err_set_c;
    logic             adr_in_rng_c;
    logic [P_ADR-1:0] acc_adr_c;
    logic [P_DAT-1:0] acc_dat_c;
    logic             acc_wr_c;
    logic [P_DAT-1:0] rd_mux_c;

    assign adr_in_rng_c = (32'(RCFG_ADR_IN) < P_REGS);

    // State register
    always_ff @(posedge CLK_IN or negedge RSTN_IN) begin
        if (!RSTN_IN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // Next state; in IDLE the live request is the access (zero-latency commit)
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        capture_c = 1'b0;
        err_set_c = 1'b0;
        acc_adr_c = adr_q;
        acc_dat_c = dat_q;
        acc_wr_c  = wr_q;
        case (state_q)
            S_IDLE: begin
                acc_adr_c = RCFG_ADR_IN;
                acc_dat_c = RCFG_DAT_IN;
                acc_wr_c  = RCFG_WR_IN;
                if (RCFG_WR_IN || RCFG_RD_IN) begin
                    capture_c = 1'b1;
                    err_set_c = (RCFG_WR_IN && RCFG_RD_IN) || (RCFG_WR_IN && !adr_in_rng_c);
                    if (P_LAT == 0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_LAT;
                        cnt_nxt   = LAT_INIT;
                    end
                end
            end
            S_LAT: begin
                if (!HOLD_IN) begin
                    if (cnt_q == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        cnt_nxt = cnt_q - CW'(1);
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign commit_c = (state_nxt == S_DONE);

    always_comb begin
        rd_mux_c = P_OOR_DAT;
        for (int k = 0; k < int'(P_REGS); k++) begin
            if (acc_adr_c == P_ADR'(k)) rd_mux_c = regs_q[k];
        end
    end

    // Capture, register bank, read data and sticky error (set wins over clear)
    always_ff @(posedge CLK_IN or negedge RSTN_IN) begin
        if (!RSTN_IN) begin
            adr_q  <= '0;
            dat_q  <= '0;
            wr_q   <= 1'b0;
            wait_q <= 1'b1;
            rdat_q <= '0;
            err_q  <= 1'b0;
            for (int k = 0; k < int'(P_REGS); k++) regs_q[k] <= '0;
        end else begin
            wait_q <= (state_nxt != S_DONE);
            err_q  <= err_set_c || (err_q && !ERR_CLR_IN);
            if (capture_c) begin
                adr_q <= RCFG_ADR_IN;
                dat_q <= RCFG_DAT_IN;
                wr_q  <= RCFG_WR_IN;
            end
            if (commit_c && !acc_wr_c) rdat_q <= rd_mux_c;
            if (commit_c && acc_wr_c) begin
                for (int k = 0; k < int'(P_REGS); k++) begin
                    if (acc_adr_c == P_ADR'(k)) regs_q[k] <= acc_dat_c;
                end
            end
        end
    end

    assign RCFG_WAIT_OUT = wait_q;
    assign RCFG_DAT_OUT  = rdat_q;
    assign ERR_OUT       = err_q;

    for (genvar g = 0; g < int'(P_REGS); g++) begin : g_export
        assign REG_OUT[g*P_DAT +: P_DAT] = regs_q[g];
    end

endmodule

// File: tb/tb_prt_rcfg_resp.sv
// Directed bench for prt_rcfg_resp: latency-2 instance driven from a vector
// table plus hand sequences, and a latency-0 instance for back-to-back writes.
module tb_prt_rcfg_resp;

    localparam int unsigned ADR  = 10;
    localparam int unsigned DAT  = 32;
    localparam int unsigned REGS = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [ADR-1:0]      adr;
    logic                wr, rd, hold, err_clr;
    logic [DAT-1:0]      wdat, rdat;
    logic                wt, err;
    logic [REGS*DAT-1:0] bank;

    logic [ADR-1:0]      adr0;
    logic                wr0, rd0, hold0, err_clr0;
    logic [DAT-1:0]      wdat0, rdat0;
    logic                wt0, err0;
    logic [REGS*DAT-1:0] bank0;

    prt_rcfg_resp #(.P_ADR(ADR), .P_DAT(DAT), .P_REGS(REGS), .P_LAT(2)) u_dut (
        .CLK_IN(clk), .RSTN_IN(rst_n), .RCFG_ADR_IN(adr), .RCFG_WR_IN(wr),
        .RCFG_RD_IN(rd), .RCFG_DAT_IN(wdat), .RCFG_DAT_OUT(rdat),
        .RCFG_WAIT_OUT(wt), .HOLD_IN(hold), .REG_OUT(bank), .ERR_OUT(err),
        .ERR_CLR_IN(err_clr)
    );

    prt_rcfg_resp #(.P_ADR(ADR), .P_DAT(DAT), .P_REGS(REGS), .P_LAT(0)) u_dut0 (
        .CLK_IN(clk), .RSTN_IN(rst_n), .RCFG_ADR_IN(adr0), .RCFG_WR_IN(wr0),
        .RCFG_RD_IN(rd0), .RCFG_DAT_IN(wdat0), .RCFG_DAT_OUT(rdat0),
        .RCFG_WAIT_OUT(wt0), .HOLD_IN(hold0), .REG_OUT(bank0), .ERR_OUT(err0),
        .ERR_CLR_IN(err_clr0)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic           wr;
        logic           rd;
        logic [ADR-1:0] adr;
        logic [DAT-1:0] dat;
        int             hold;
        logic           clr;
        int             exp_lat;
        logic [DAT-1:0] exp_rdat;
        logic           exp_err;
        int             reg_idx;
        logic [DAT-1:0] exp_reg;
    } vec_t;

    vec_t vecs[8];

    // One access starting at cycle 0 (called just after a rising edge)
    task automatic do_access(input vec_t v, input string tag);
        int low_at;
        low_at = -1;
        wr = v.wr; rd = v.rd; adr = v.adr; wdat = v.dat; err_clr = v.clr;
        for (int cyc = 0; cyc < 40; cyc++) begin
            hold = (cyc >= 1) && (cyc <= v.hold);
            if (cyc == 1) err_clr = 1'b0;
            @(negedge clk);
            if (wt == 1'b0) begin
                low_at = cyc;
                chk({tag, "_rdat"}, rdat, v.exp_rdat);
                chk({tag, "_err"}, 32'(err), 32'(v.exp_err));
                chk({tag, "_reg"}, bank[v.reg_idx*DAT +: DAT], v.exp_reg);
            end
            @(posedge clk); #1;
            if (low_at >= 0) break;
        end
        wr = 1'b0; rd = 1'b0; hold = 1'b0; err_clr = 1'b0;
        chk({tag, "_lat"}, 32'(low_at), 32'(v.exp_lat));
        @(negedge clk);
        chk({tag, "_one_low"}, 32'(wt), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic clear_err(input string tag);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk(tag, 32'(err), 32'd0);
        @(posedge clk); #1;
    endtask

    logic exp_w0 [6];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 10'd5,  32'h1234_5678, 0, 1'b0, 3, 32'h0,         1'b0, 5,  32'h1234_5678};
        vecs[1] = '{1'b0, 1'b1, 10'd5,  32'h0,         0, 1'b0, 3, 32'h1234_5678, 1'b0, 5,  32'h1234_5678};
        vecs[2] = '{1'b0, 1'b1, 10'd0,  32'h0,         4, 1'b0, 7, 32'h0,         1'b0, 0,  32'h0};
        vecs[3] = '{1'b1, 1'b0, 10'd20, 32'hFFFF_FFFF, 0, 1'b0, 3, 32'h0,         1'b1, 4,  32'h0};
        vecs[4] = '{1'b0, 1'b1, 10'd20, 32'h0,         0, 1'b0, 3, 32'hDEAD_BEEF, 1'b1, 5,  32'h1234_5678};
        vecs[5] = '{1'b1, 1'b1, 10'd1,  32'hA5A5_A5A5, 0, 1'b0, 3, 32'hDEAD_BEEF, 1'b1, 1,  32'hA5A5_A5A5};
        vecs[6] = '{1'b1, 1'b0, 10'd31, 32'h0000_0001, 0, 1'b1, 3, 32'hDEAD_BEEF, 1'b1, 15, 32'h0};
        vecs[7] = '{1'b0, 1'b1, 10'd1,  32'h0,         0, 1'b0, 3, 32'hA5A5_A5A5, 1'b1, 1,  32'hA5A5_A5A5};
        exp_w0 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0;
        adr = '0; wr = 1'b0; rd = 1'b0; wdat = '0; hold = 1'b0; err_clr = 1'b0;
        adr0 = '0; wr0 = 1'b0; rd0 = 1'b0; wdat0 = '0; hold0 = 1'b0; err_clr0 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("init_wait", 32'(wt), 32'd1);
        chk("init_bank_zero", 32'(bank == '0), 32'd1);
        chk("init_rdat", rdat, 32'h0);
        chk("init_err", 32'(err), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            if (i == 5) clear_err("clr_after_oor");
            if (i == 6) clear_err("clr_after_conflict");
            do_access(vecs[i], $sformatf("v%0d", i));
        end

        // Reset asserted in the latency phase of a write to addr 3
        wr = 1'b1; adr = 10'd3; wdat = 32'h0000_0077;
        @(posedge clk); #3;
        rst_n = 1'b0; wr = 1'b0;
        #1;
        chk("rst_wait", 32'(wt), 32'd1);
        chk("rst_bank_zero", 32'(bank == '0), 32'd1);
        chk("rst_rdat", rdat, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_reg3", bank[3*DAT +: DAT], 32'h0);
        chk("rst_wait_after", 32'(wt), 32'd1);
        @(posedge clk); #1;

        // Zero-latency instance: request held across two back-to-back writes
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc == 0) begin wr0 = 1'b1; adr0 = 10'd2; wdat0 = 32'h0000_0011; end
            if (cyc == 2) begin adr0 = 10'd3; wdat0 = 32'h0000_0022; end
            if (cyc == 4) wr0 = 1'b0;
            @(negedge clk);
            chk($sformatf("lat0_wait_c%0d", cyc), 32'(wt0), 32'(exp_w0[cyc]));
            @(posedge clk); #1;
        end
        chk("lat0_reg2", bank0[2*DAT +: DAT], 32'h0000_0011);
        chk("lat0_reg3", bank0[3*DAT +: DAT], 32'h0000_0022);
        chk("lat0_err", 32'(err0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
